uart_tx_fifo_drain: RTL and testbench
=====================================

Name: uart_tx_fifo_drain

Overview:
- Read-side consumer of the 8-bit synchronous RAM FIFO.
- Pops bytes from the FIFO read port and serialises each one as a UART 8N1 frame on oTx.
- Used for the DMM IceBreaker host link: producers write measurement bytes into the FIFO, and this block drains them to the FTDI UART.
- Handles the FIFO's one-cycle registered read latency internally.

Parameters:
- pClkFreq, 12000000, system clock frequency in Hz.
- pBaud, 115200, line rate in bit/s.
- pClksPerBit, pClkFreq/pBaud (104), clocks per UART bit. Must be >= 2. A local override is permitted for simulation.

Ports:
- iClk  input  1  system clock, rising edge.
- iRstN  input  1  asynchronous active-low reset.
- iEnable  input  1  permits fetching new bytes. Sampled only in IDLE.
- iFifoEmpty  input  1  FIFO empty flag.
- iFifoRdData  input  8  FIFO read data. Valid the cycle after a read strobe and held until the next strobe.
- oFifoRdEn  output  1  FIFO read strobe (pop). Combinational, single cycle.
- oTx  output  1  UART serial line. Idle high.
- oBusy  output  1  high in any state other than IDLE.
- oByteDone  output  1  one-cycle pulse on the last clock of each stop bit.

Behaviour:
- Reset (iRstN low, asynchronous):
  - State is IDLE.
  - oTx = 1, oBusy = 0, oByteDone = 0, oFifoRdEn = 0.
  - Baud counter, bit index and shift register are 0.
  - Reset asserted mid-frame aborts the frame immediately and drives oTx high. No partial byte is retried.
- States: IDLE, LOAD, START, DATA, STOP.
- IDLE:
  - oFifoRdEn = iEnable && !iFifoEmpty, combinational.
  - If oFifoRdEn is high, next state is LOAD. Otherwise stay in IDLE.
  - This is the only state that asserts oFifoRdEn, so there is exactly one pop per frame.
- LOAD (exactly 1 cycle):
  - iFifoRdData is now valid. Capture it into the 8-bit shift register at the end of the cycle.
  - Clear the baud counter; next state is START.
  - oTx stays 1.
  - iFifoEmpty and iEnable are ignored here.
- START: oTx = 0 for exactly pClksPerBit cycles, then go to DATA with bit index 0.
- DATA:
  - oTx = shift register bit 0, LSB first.
  - Each bit lasts pClksPerBit cycles. At the end of each bit, shift right by one and increment the bit index.
  - After bit 7 completes, go to STOP.
- STOP:
  - oTx = 1 for pClksPerBit cycles.
  - oByteDone = 1 on the final cycle of the stop bit, then return to IDLE.
- Baud counter:
  - Width is $clog2(pClksPerBit).
  - Counts 0 to pClksPerBit-1, then wraps to 0 at each bit boundary.
  - No cumulative drift: the frame is exactly 10*pClksPerBit cycles from the first START cycle to the last STOP cycle.
- Latency:
  - Read strobe cycle N; LOAD is cycle N+1; the first START cycle (oTx falls) is N+2.
  - Back-to-back frames: STOP is followed by IDLE (1 cycle, strobe issued) and LOAD (1 cycle). Minimum gap between stop-bit end and the next start bit is therefore 2 clocks of idle high. This is legal UART.
- iEnable deassert mid-frame: the current frame completes unchanged. No further pops occur until iEnable is high again in IDLE.
- FIFO empty while in IDLE: no strobe, oTx held high indefinitely.
- All outputs except oFifoRdEn are registered. oTx has no glitches.
- Integration: the FIFO reset is synchronous active-high, so the top level drives it with the inverted, synchronised iRstN. That inversion is outside this block.

Test Plan:
- Single byte, no back-pressure: pClksPerBit = 4, FIFO preloaded with 0xA5, iEnable = 1.
  - Exactly one oFifoRdEn pulse.
  - oTx falls 2 cycles later.
  - Line reads 0, 1,0,1,0,0,1,0,1, 1, each bit held 4 clocks (40 clocks total).
  - oByteDone pulses on clock 40.
  - FIFO ends empty and oTx stays 1.
- Back-to-back: FIFO holds 0x00, 0xFF, 0x3C.
  - Three frames decode in order.
  - Exactly 2 idle-high clocks between frames.
  - Three oByteDone pulses and three read strobes.
- Empty / disabled: FIFO empty with iEnable = 1 for 200 clocks, then one byte written with iEnable = 0 for 100 clocks.
  - No strobe and oTx = 1 throughout.
  - On setting iEnable = 1, the strobe occurs in the same cycle.
- Enable drop mid-frame: 2 bytes queued, iEnable deasserted during DATA bit 3 of frame 1.
  - Frame 1 completes fully.
  - Second byte stays in the FIFO (empty = 0) and no strobe occurs.
- Reset mid-frame: assert iRstN low asynchronously during DATA bit 5.
  - oTx = 1 and oBusy = 0 before the next clock edge.
  - After release with 1 byte queued, a clean full frame of that byte follows.
- Rate check: default parameters, byte 0x55.
  - Every bit period measures exactly 104 clocks.
  - Frame length is 1040 clocks.

Source files
------------

// File: rtl/uart_tx_fifo_drain.sv
// Drains bytes from a synchronous-read FIFO and sends each as a UART 8N1 frame.
// Exactly one pop per frame; the registered FIFO read latency is absorbed by LOAD.
`timescale 1ns/1ps

module uart_tx_fifo_drain #(
    parameter int unsigned pClkFreq    = 12000000,
    parameter int unsigned pBaud       = 115200,
    parameter int unsigned pClksPerBit = pClkFreq / pBaud
) (
    input  logic       iClk,
    input  logic       iRstN,
    input  logic       iEnable,
    input  logic       iFifoEmpty,
    input  logic [7:0] iFifoRdData,
    output logic       oFifoRdEn,
    output logic       oTx,
    output logic       oBusy,
    output logic       oByteDone
);

    localparam int unsigned CNT_W = (pClksPerBit > 1) ? $clog2(pClksPerBit) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(pClksPerBit - 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} tState;

    tState            state, stateNext;
    logic [CNT_W-1:0] baudCnt, baudCntNext, baudCntInc;
    logic [2:0]       bitIdx, bitIdxNext;
    logic [7:0]       shiftReg, shiftRegNext;
    logic             txReg, busyReg, byteDoneReg;
    logic             txNext, busyNext, byteDoneNext;
    logic             bitEnd, fetch;

    assign bitEnd     = (baudCnt == CNT_LAST);
    assign baudCntInc = bitEnd ? '0 : baudCnt + 1'b1;
    // Gated by iRstN so no pop can be issued while the block is held in reset.
    assign fetch      = (state == IDLE) && iRstN && iEnable && !iFifoEmpty;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state       <= IDLE;
            baudCnt     <= '0;
            bitIdx      <= '0;
            shiftReg    <= '0;
            txReg       <= 1'b1;
            busyReg     <= 1'b0;
            byteDoneReg <= 1'b0;
        end else begin
            state       <= stateNext;
            baudCnt     <= baudCntNext;
            bitIdx      <= bitIdxNext;
            shiftReg    <= shiftRegNext;
            txReg       <= txNext;
            busyReg     <= busyNext;
            byteDoneReg <= byteDoneNext;
        end
    end

    always_comb begin
        stateNext    = state;
        baudCntNext  = baudCnt;
        bitIdxNext   = bitIdx;
        shiftRegNext = shiftReg;
        case (state)
            IDLE: begin
                baudCntNext = '0;
                if (fetch) stateNext = LOAD;
            end
            LOAD: begin
                shiftRegNext = iFifoRdData;
                baudCntNext  = '0;
                stateNext    = START;
            end
            START: begin
                baudCntNext = baudCntInc;
                if (bitEnd) begin
                    bitIdxNext = '0;
                    stateNext  = DATA;
                end
            end
            DATA: begin
                baudCntNext = baudCntInc;
                if (bitEnd) begin
                    shiftRegNext = {1'b0, shiftReg[7:1]};
                    bitIdxNext   = bitIdx + 1'b1;
                    if (bitIdx == 3'd7) stateNext = STOP;
                end
            end
            STOP: begin
                baudCntNext = baudCntInc;
                if (bitEnd) stateNext = IDLE;
            end
            default: begin
                stateNext   = IDLE;
                baudCntNext = '0;
            end
        endcase
    end

    // Line outputs are derived from the next state so they register glitch-free
    // and line up with the state they describe.
    always_comb begin
        oFifoRdEn    = fetch;
        busyNext     = (stateNext != IDLE);
        byteDoneNext = (stateNext == STOP) && (baudCntNext == CNT_LAST);
        case (stateNext)
            START:   txNext = 1'b0;
            DATA:    txNext = shiftRegNext[0];
            default: txNext = 1'b1;
        endcase
    end

    assign oTx       = txReg;
    assign oBusy     = busyReg;
    assign oByteDone = byteDoneReg;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain: a fast instance (4 clocks/bit) with a
// small FIFO model, and a default-rate instance for the bit-timing check.
`timescale 1ns/1ps

module tb_uart_tx_fifo_drain;

    logic       clk = 1'b0;
    logic       rstN;
    logic       enable1, empty1, rdEn1, tx1, busy1, done1;
    logic [7:0] rdData1;
    logic       enable2, empty2, rdEn2, tx2, busy2, done2;
    logic [7:0] rdData2;

    logic [7:0] mem [0:31];
    int wrPtr = 0, rdPtr = 0;
    int wr2 = 0, rd2 = 0;
    int cycleCnt = 0, strobeCnt = 0, doneCnt = 0, lastStrobe = 0;
    int passCnt = 0, failCnt = 0, totalCnt = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_drain #(.pClksPerBit(4)) dut1 (
        .iClk(clk), .iRstN(rstN), .iEnable(enable1), .iFifoEmpty(empty1),
        .iFifoRdData(rdData1), .oFifoRdEn(rdEn1), .oTx(tx1), .oBusy(busy1),
        .oByteDone(done1)
    );

    uart_tx_fifo_drain dut2 (
        .iClk(clk), .iRstN(rstN), .iEnable(enable2), .iFifoEmpty(empty2),
        .iFifoRdData(rdData2), .oFifoRdEn(rdEn2), .oTx(tx2), .oBusy(busy2),
        .oByteDone(done2)
    );

    // FIFO model: registered read data, held until the next pop.
    assign empty1  = (wrPtr == rdPtr);
    assign empty2  = (wr2 == rd2);
    assign rdData2 = 8'h55;

    always @(posedge clk) begin
        cycleCnt = cycleCnt + 1;
        if (rdEn1 === 1'b1) begin
            rdData1 <= mem[rdPtr % 32];
            rdPtr   <= rdPtr + 1;
        end
        if (rdEn2 === 1'b1) rd2 <= rd2 + 1;
    end

    always @(negedge clk) begin
        if (rdEn1 === 1'b1) begin
            strobeCnt  = strobeCnt + 1;
            lastStrobe = cycleCnt;
        end
        if (done1 === 1'b1) doneCnt = doneCnt + 1;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wrPtr % 32] = b;
        wrPtr = wrPtr + 1;
    endtask

    task automatic waitStart(input bit sel, input int limit, output bit found, output int cyc);
        found = 1'b0;
        cyc   = 0;
        for (int n = 0; n < limit && !found; n++) begin
            @(negedge clk);
            if ((sel ? tx2 : tx1) === 1'b0) begin
                found = 1'b1;
                cyc   = cycleCnt;
            end
        end
    endtask

    task automatic checkFrame(input bit sel, input logic [7:0] b, input int p,
                              input string tag, output int sCyc, output int eCyc);
        logic [9:0] frame;
        int bad [10];
        int doneHits, doneIdx;
        bit found;
        frame = {1'b1, b, 1'b0};
        foreach (bad[k]) bad[k] = 0;
        doneHits = 0;
        doneIdx  = -1;
        waitStart(sel, 12 * p + 64, found, sCyc);
        chk({tag, "_start"}, {31'b0, found}, 32'd1);
        for (int i = 0; i < 10 * p; i++) begin
            if (i > 0) @(negedge clk);
            if ((sel ? tx2 : tx1) !== frame[i / p]) bad[i / p]++;
            if ((sel ? done2 : done1) === 1'b1) begin
                doneHits++;
                doneIdx = i;
            end
        end
        eCyc = cycleCnt;
        for (int k = 0; k < 10; k++) chk($sformatf("%s_bit%0d", tag, k), bad[k], 0);
        chk({tag, "_doneHits"}, doneHits, 1);
        chk({tag, "_doneIdx"}, doneIdx, 10 * p - 1);
    endtask

    initial begin
        int s, e, s2, e2, s3, e3, s0, d0, bad, cdrop;
        bit fnd;

        // Reset: outputs idle and no pop even with data and enable present.
        rstN = 1'b0;
        enable1 = 1'b1;
        enable2 = 1'b0;
        push(8'hA5);
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'b0, tx1}, 32'd1);
        chk("rst_busy", {31'b0, busy1}, 32'd0);
        chk("rst_done", {31'b0, done1}, 32'd0);
        chk("rst_rden", {31'b0, rdEn1}, 32'd0);

        // Single byte 0xA5.
        s0 = strobeCnt; d0 = doneCnt;
        @(posedge clk); #1 rstN = 1'b1;
        checkFrame(1'b0, 8'hA5, 4, "single", s, e);
        chk("single_latency", s - lastStrobe, 2);
        repeat (5) @(negedge clk);
        chk("single_strobes", strobeCnt - s0, 1);
        chk("single_dones", doneCnt - d0, 1);
        chk("single_empty", {31'b0, empty1}, 32'd1);
        chk("single_idle_tx", {31'b0, tx1}, 32'd1);
        chk("single_idle_busy", {31'b0, busy1}, 32'd0);

        // Back-to-back frames with a 2-clock idle gap.
        s0 = strobeCnt; d0 = doneCnt;
        @(posedge clk); #1 push(8'h00); push(8'hFF); push(8'h3C);
        checkFrame(1'b0, 8'h00, 4, "b2b0", s, e);
        checkFrame(1'b0, 8'hFF, 4, "b2b1", s2, e2);
        checkFrame(1'b0, 8'h3C, 4, "b2b2", s3, e3);
        chk("b2b_gap1", s2 - e, 3);
        chk("b2b_gap2", s3 - e2, 3);
        repeat (5) @(negedge clk);
        chk("b2b_strobes", strobeCnt - s0, 3);
        chk("b2b_dones", doneCnt - d0, 3);

        // Empty with enable, then data with enable low.
        s0 = strobeCnt;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx1 !== 1'b1 || rdEn1 !== 1'b0) bad++;
        end
        chk("idle_empty", bad, 0);
        @(posedge clk); #1 enable1 = 1'b0; push(8'h81);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx1 !== 1'b1 || rdEn1 !== 1'b0) bad++;
        end
        chk("idle_disabled", bad, 0);
        chk("idle_no_strobe", strobeCnt - s0, 0);
        @(posedge clk); #1 enable1 = 1'b1;
        #1 chk("enable_same_cycle", {31'b0, rdEn1}, 32'd1);
        checkFrame(1'b0, 8'h81, 4, "enable", s, e);

        // Enable dropped during DATA bit 3 of the first of two queued frames.
        repeat (3) @(negedge clk);
        @(posedge clk); #1 enable1 = 1'b0; push(8'h96); push(8'h5A);
        s0 = strobeCnt;
        @(posedge clk); #1 enable1 = 1'b1;
        fork
            checkFrame(1'b0, 8'h96, 4, "drop", s, e);
            begin
                waitStart(1'b0, 64, fnd, cdrop);
                if (fnd) begin
                    repeat (18) @(posedge clk);
                    #1 enable1 = 1'b0;
                end
            end
        join
        repeat (20) @(negedge clk);
        chk("drop_strobes", strobeCnt - s0, 1);
        chk("drop_not_empty", {31'b0, empty1}, 32'd0);
        chk("drop_tx", {31'b0, tx1}, 32'd1);
        chk("drop_busy", {31'b0, busy1}, 32'd0);

        // Reset during DATA bit 5 of 0x5A (bit 5 is 0).
        s0 = strobeCnt;
        @(posedge clk); #1 enable1 = 1'b1;
        waitStart(1'b0, 64, fnd, cdrop);
        chk("rstmid_start", {31'b0, fnd}, 32'd1);
        repeat (25) @(posedge clk);
        #1 chk("rstmid_pre_tx", {31'b0, tx1}, 32'd0);
        rstN = 1'b0;
        #1 chk("rstmid_tx", {31'b0, tx1}, 32'd1);
        chk("rstmid_busy", {31'b0, busy1}, 32'd0);
        push(8'hC3);
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;
        checkFrame(1'b0, 8'hC3, 4, "after_rst", s, e);
        repeat (5) @(negedge clk);
        chk("after_rst_strobes", strobeCnt - s0, 2);
        chk("after_rst_empty", {31'b0, empty1}, 32'd1);

        // Default rate: 104 clocks per bit.
        @(posedge clk); #1 wr2 = 1; enable2 = 1'b1;
        checkFrame(1'b1, 8'h55, 104, "rate", s, e);
        chk("rate_len", e - s + 1, 1040);
        repeat (3) @(negedge clk);
        chk("rate_busy", {31'b0, busy2}, 32'd0);
        chk("rate_tx", {31'b0, tx2}, 32'd1);
        chk("rate_empty", {31'b0, empty2}, 32'd1);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
